bus_coherence_ctrl: RTL and testbench

//  Memory-side coherence bus controller; the responder end of the dcache

---
 rtl/bus_coherence_ctrl_pkg.sv | 30 +++
 rtl/bus_coherence_ctrl_rr_arbiter.sv | 26 ++
 rtl/bus_coherence_ctrl.sv | 153 +++++++++++++++
 tb/tb_bus_coherence_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_coherence_ctrl_pkg.sv
// Shared types for the two-cache coherence bus controller: bus FSM states,
// RAM handshake states and the block-offset mask used to form block bases.
package bus_coherence_ctrl_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [3:0] {
        IDLE,
        SNOOP,
        WB0,
        WB1,
        C2C0,
        C2C1,
        RD0,
        RD1
    } bus_state_t;

    localparam logic [31:0] BLK_OFF_MASK = 32'hFFFF_FFFB;

    // A block is two words; the word select lands on address bit 2.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic word);
        return base | {29'd0, word, 2'b00};
    endfunction

endpackage

// File: rtl/bus_coherence_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the cache holding priority, and priority passes to the other cache on completion.
module rr_arbiter
    import bus_coherence_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_owner,
    output logic       o_gnt_id
);

    logic r_prio;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (i_advance) begin
            r_prio <= ~i_owner;
        end
    end

    assign o_gnt_id = (&i_req) ? r_prio : i_req[1];

endmodule

// File: rtl/bus_coherence_ctrl.sv
// Memory-side coherence bus controller for two dcaches: arbitrates one RAM
// port, snoops the other cache, and serves misses by cache-to-cache or RAM.
module bus_coherence_ctrl
    import bus_coherence_ctrl_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int SNOOP_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
    localparam logic [CNT_W-1:0] SNOOP_LAST = CNT_W'(SNOOP_LAT - 1);

    bus_state_t       r_state;
    bus_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_ccwrite;
    logic [31:0]      r_base;

    logic [CPUS-1:0]  w_req;
    logic             w_gnt;
    logic             w_grant;
    logic             w_done;
    logic             w_snp;
    logic             w_word;
    logic             w_access;
    logic             w_snp_last;
    logic [31:0]      w_addr;

    // Snoop-supply (dWEN & cctrans) and plain reads (dREN & ~cctrans) are not bus requests.
    assign w_req      = (dWEN & ~cctrans) | (dREN & cctrans);
    assign w_snp      = ~r_req;
    assign w_access   = (ramstate == ACCESS);
    assign w_word     = (r_state == WB1) || (r_state == C2C1) || (r_state == RD1);
    assign w_addr     = beat_addr(r_base, w_word);
    assign w_snp_last = (r_cnt == SNOOP_LAST);

    rr_arbiter u_arb (
        .i_clk     (CLK),
        .i_rst_n   (nRST),
        .i_req     (w_req),
        .i_advance (w_done),
        .i_owner   (r_req),
        .o_gnt_id  (w_gnt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SNOOP && !w_snp_last) ? r_cnt + 1'b1 : '0;
        end
    end

    // Transaction context is only consumed outside IDLE, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_grant) begin
            r_req     <= w_gnt;
            r_base    <= daddr[w_gnt] & BLK_OFF_MASK;
            r_ccwrite <= ccwrite[w_gnt];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        if (r_state inside {SNOOP, C2C0, C2C1, RD0, RD1}) begin
            ccwait[w_snp]      = 1'b1;
            ccinv[w_snp]       = r_ccwrite;
            ccsnoopaddr[w_snp] = r_base;
        end

        unique case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant = 1'b1;
                    w_next  = (dWEN[w_gnt] & ~cctrans[w_gnt]) ? WB0 : SNOOP;
                end
            end
            SNOOP: begin
                if (w_snp_last) begin
                    w_next = cctrans[w_snp] ? C2C0 : RD0;
                end
            end
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = w_addr;
                ramstore = dstore[r_req];
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    w_next       = (r_state == WB0) ? WB1 : IDLE;
                end
            end
            C2C0, C2C1: begin
                // Snooper's dirty data goes to the requester and to RAM in the same beat.
                ramWEN       = 1'b1;
                ramaddr      = w_addr;
                ramstore     = dstore[w_snp];
                dload[r_req] = dstore[w_snp];
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    dwait[w_snp] = 1'b0;
                    w_next       = (r_state == C2C0) ? C2C1 : IDLE;
                end
            end
            RD0, RD1: begin
                ramREN       = 1'b1;
                ramaddr      = w_addr;
                dload[r_req] = ramload;
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    w_next       = (r_state == RD0) ? RD1 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase

        w_done = (r_state != IDLE) && (w_next == IDLE);
    end

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Scoreboard bench for bus_coherence_ctrl: expected RAM beats are queued as
// transactions are issued and compared whenever the RAM model grants ACCESS.
module tb_bus_coherence_ctrl;
    import bus_coherence_ctrl_pkg::*;

    localparam int SNOOP_LAT = 2;
    localparam logic [31:0] LOAD_KEY = 32'h5A5A_0000;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic        ren;
        logic [31:0] store;
        logic [1:0]  dw;
        logic [63:0] dl;
        logic [1:0]  cw;
        logic [1:0]  ci;
        logic [63:0] sa;
    } beat_t;

    beat_t sb_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    busy_n = 0;
    int    wcnt   = 0;

    bus_coherence_ctrl #(.CPUS(2), .SNOOP_LAT(SNOOP_LAT)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    always #5 CLK = ~CLK;

    assign ramload = ramaddr ^ LOAD_KEY;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int c);
        return (c == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [63:0] place(input int c, input logic [31:0] v);
        return (c == 0) ? {32'h0, v} : {v, 32'h0};
    endfunction

    function automatic void exp_wb(input int c, input logic [31:0] base,
                                   input logic [31:0] d0, input logic [31:0] d1);
        beat_t e;
        for (int k = 0; k < 2; k++) begin
            e       = '0;
            e.addr  = base | (k == 1 ? 32'h4 : 32'h0);
            e.wen   = 1'b1;
            e.store = (k == 1) ? d1 : d0;
            e.dw    = ~onehot(c);
            sb_q.push_back(e);
        end
    endfunction

    function automatic void exp_rd(input int c, input logic [31:0] base, input logic ccw, input int nb);
        beat_t e;
        int    s = 1 - c;
        for (int k = 0; k < nb; k++) begin
            e      = '0;
            e.addr = base | (k == 1 ? 32'h4 : 32'h0);
            e.ren  = 1'b1;
            e.dw   = ~onehot(c);
            e.dl   = place(c, e.addr ^ LOAD_KEY);
            e.cw   = onehot(s);
            e.ci   = ccw ? onehot(s) : 2'b00;
            e.sa   = place(s, base);
            sb_q.push_back(e);
        end
    endfunction

    function automatic void exp_c2c(input int c, input logic [31:0] base, input logic ccw,
                                    input logic [31:0] d0, input logic [31:0] d1);
        beat_t e;
        int    s = 1 - c;
        for (int k = 0; k < 2; k++) begin
            e       = '0;
            e.addr  = base | (k == 1 ? 32'h4 : 32'h0);
            e.wen   = 1'b1;
            e.store = (k == 1) ? d1 : d0;
            e.dw    = 2'b00;
            e.dl    = place(c, e.store);
            e.cw    = onehot(s);
            e.ci    = ccw ? onehot(s) : 2'b00;
            e.sa    = place(s, base);
            sb_q.push_back(e);
        end
    endfunction

    // RAM model and scoreboard monitor: ramstate is set at the falling edge, outputs sampled just after.
    always @(negedge CLK) begin
        beat_t e;
        if (!nRST || !(ramREN || ramWEN)) begin
            ramstate = FREE;
            wcnt     = 0;
        end else if (wcnt < busy_n) begin
            ramstate = BUSY;
            wcnt++;
        end else begin
            ramstate = ACCESS;
            wcnt     = 0;
        end
        #2;
        if (nRST && (ramREN || ramWEN)) begin
            if (ramstate == ACCESS) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("beat_ramaddr",  ramaddr,     e.addr);
                    check_val("beat_ramWEN",   ramWEN,      e.wen);
                    check_val("beat_ramREN",   ramREN,      e.ren);
                    check_val("beat_ramstore", ramstore,    e.store);
                    check_val("beat_dwait",    dwait,       e.dw);
                    check_val("beat_dload",    dload,       e.dl);
                    check_val("beat_ccwait",   ccwait,      e.cw);
                    check_val("beat_ccinv",    ccinv,       e.ci);
                    check_val("beat_snpaddr",  ccsnoopaddr, e.sa);
                end
            end else if (ramstate == BUSY) begin
                check_val("busy_dwait", dwait, 2'b11);
                if (sb_q.size() > 0) begin
                    check_val("busy_ramaddr", ramaddr, sb_q[0].addr);
                    check_val("busy_ramWEN",  ramWEN,  sb_q[0].wen);
                end
            end
        end
    end

    task automatic wait_beat(input int c, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            #3;
            if (dwait[c] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val($sformatf("beat_timeout_c%0d", c), {63'd0, ok}, 64'd1);
    endtask

    // One cache's side of a two-beat transaction (requester or snoop supplier).
    task automatic drive(input int c, input logic wen, input logic ren, input logic trn,
                         input logic ccw, input logic [31:0] base,
                         input logic [31:0] d0, input logic [31:0] d1);
        bit ok;
        dWEN[c]    = wen;
        dREN[c]    = ren;
        cctrans[c] = trn;
        ccwrite[c] = ccw;
        daddr[c]   = base;
        dstore[c]  = d0;
        for (int k = 0; k < 2; k++) begin
            wait_beat(c, ok);
            if (!ok) break;
            @(posedge CLK);
            #1;
            daddr[c]  = base | 32'h4;
            dstore[c] = d1;
        end
        dWEN[c]    = 1'b0;
        dREN[c]    = 1'b0;
        cctrans[c] = 1'b0;
        ccwrite[c] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_dwait"},   dwait,       2'b11);
        check_val({tag, "_ccwait"},  ccwait,      2'b00);
        check_val({tag, "_ccinv"},   ccinv,       2'b00);
        check_val({tag, "_ramREN"},  ramREN,      1'b0);
        check_val({tag, "_ramWEN"},  ramWEN,      1'b0);
        check_val({tag, "_ramaddr"}, ramaddr,     32'h0);
        check_val({tag, "_dload"},   dload,       64'h0);
        check_val({tag, "_snpaddr"}, ccsnoopaddr, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        nRST     = 1'b0;
        dREN     = '0;
        dWEN     = '0;
        cctrans  = '0;
        ccwrite  = '0;
        daddr    = '0;
        dstore   = '0;
        ramstate = FREE;
        repeat (3) @(posedge CLK);
        #1;
        check_idle("rst");
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check_idle("post_rst");

        // Cache0 writeback
        exp_wb(0, 32'h100, 32'hAAAA, 32'hBBBB);
        drive(0, 1, 0, 0, 0, 32'h100, 32'hAAAA, 32'hBBBB);

        // Cache1 read miss, cache0 clean: snoop then RAM read
        exp_rd(1, 32'h200, 1'b0, 2);
        fork
            drive(1, 0, 1, 1, 0, 32'h200, 32'h0, 32'h0);
            begin
                for (int i = 0; i < 100 && ccwait == 2'b00; i++) begin
                    @(negedge CLK);
                    #3;
                end
                check_val("rd_snoop_ccwait",  ccwait,         2'b01);
                check_val("rd_snoop_addr",    ccsnoopaddr[0], 32'h200);
                check_val("rd_snoop_ccinv",   ccinv,          2'b00);
                n = 0;
                while (!(ramREN || ramWEN) && n < 100) begin
                    n++;
                    @(negedge CLK);
                    #3;
                end
                check_val("rd_snoop_cycles", n, SNOOP_LAT);
            end
        join

        // Cache0 read-exclusive, cache1 supplies dirty block
        exp_c2c(0, 32'h340, 1'b1, 32'h11, 32'h22);
        fork
            drive(0, 0, 1, 1, 1, 32'h340, 32'h0, 32'h0);
            drive(1, 1, 0, 1, 0, 32'h340, 32'h11, 32'h22);
        join

        // Slow RAM: three BUSY cycles before every ACCESS
        busy_n = 3;
        exp_wb(1, 32'h600, 32'h6060, 32'h6161);
        drive(1, 1, 0, 0, 0, 32'h600, 32'h6060, 32'h6161);
        exp_rd(0, 32'h700, 1'b1, 2);
        drive(0, 0, 1, 1, 1, 32'h704, 32'h0, 32'h0);

        // Reset in the middle of the second read beat
        busy_n = 2;
        exp_rd(1, 32'h500, 1'b0, 1);
        dREN[1]    = 1'b1;
        cctrans[1] = 1'b1;
        daddr[1]   = 32'h500;
        wait_beat(1, ok);
        @(posedge CLK);
        @(negedge CLK);
        #3;
        check_val("rst_mid_pre_ramaddr", ramaddr, 32'h504);
        nRST = 1'b0;
        #1;
        check_idle("rst_mid");
        dREN[1]    = 1'b0;
        cctrans[1] = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        check_val("rst_mid_sb_empty", sb_q.size(), 0);
        @(posedge CLK);
        #1;
        check_idle("rst_mid_after");
        busy_n = 0;

        // Both caches write back at once, then re-request: strict alternation 0,1,0,1
        exp_wb(0, 32'h800, 32'hA0, 32'hA1);
        exp_wb(1, 32'h900, 32'hB0, 32'hB1);
        exp_wb(0, 32'h880, 32'hC0, 32'hC1);
        exp_wb(1, 32'h980, 32'hD0, 32'hD1);
        fork
            begin
                drive(0, 1, 0, 0, 0, 32'h800, 32'hA0, 32'hA1);
                drive(0, 1, 0, 0, 0, 32'h880, 32'hC0, 32'hC1);
            end
            begin
                drive(1, 1, 0, 0, 0, 32'h900, 32'hB0, 32'hB1);
                drive(1, 1, 0, 0, 0, 32'h980, 32'hD0, 32'hD1);
            end
        join

        repeat (4) @(posedge CLK);
        #1;
        check_val("sb_drain", sb_q.size(), 0);
        check_idle("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
